// File: rtl/svm_pkg.sv
// svm_pkg: shared tag encodings, zero-word helper and FSM states for the SVM kernel accumulator
package svm_pkg;
  localparam logic [1:0] TAG_POS  = 2'b00;
  localparam logic [1:0] TAG_NEG  = 2'b01;
  localparam logic [1:0] TAG_ZERO = 2'b10;
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_e;
  // Tagged zero word {2'b10, 0...} for a word of width w (w <= 64)
  function automatic logic [63:0] zero_word(input int w);
    return {62'd0, TAG_ZERO} << (w - 2);
  endfunction
endpackage

// File: rtl/svm_adder_tree.sv
// svm_adder_tree: pipelined LANES-input magnitude adder tree with tag masking and overflow propagation; SVM_ACC_SAT_EN saturates
module svm_adder_tree
  import svm_pkg::*;
#(
  parameter int LANES = 4,
  parameter int MAG_W = 30,
  parameter int SB_W  = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           valid_i,
  input  logic [LANES*(MAG_W+2)-1:0]     terms_i,
  input  logic [SB_W-1:0]                sb_i,
  output logic                           valid_o,
  output logic [MAG_W-1:0]               sum_o,
  output logic                           ovf_o,
  output logic [SB_W-1:0]                sb_o
);
  localparam int W = MAG_W + 2;
  localparam int D = $clog2(LANES);
  localparam int N = 2 * LANES - 1;
  // Heap layout: nodes 0..LANES-2 are registered sums, LANES-1..N-1 are the masked lane leaves
  logic [MAG_W-1:0] node_q [LANES-1];
  logic [LANES-2:0] nov_q;
  logic [MAG_W-1:0] val [N];
  logic [N-1:0]     vov;
  logic [MAG_W:0]   s [LANES-1];
  logic [MAG_W-1:0] nxt [LANES-1];
  logic [LANES-2:0] so;
  logic [D-1:0]     vld_q;
  logic [SB_W-1:0]  sb_q [D];
  // Gather node values, mask zero/invalid lanes, and form each node's next sum with carry
  always_comb begin
    logic [1:0] tag;
    tag = '0;
    for (int n = 0; n < LANES - 1; n++) begin
      val[n] = node_q[n];
      vov[n] = nov_q[n];
    end
    for (int l = 0; l < LANES; l++) begin
      tag = terms_i[l*W+MAG_W +: 2];
      val[LANES-1+l] = (tag == TAG_POS || tag == TAG_NEG) ? terms_i[l*W +: MAG_W] : '0;
      vov[LANES-1+l] = 1'b0;
    end
    for (int n = 0; n < LANES - 1; n++) begin
      s[n]  = {1'b0, val[2*n+1]} + {1'b0, val[2*n+2]};
      so[n] = s[n][MAG_W] | vov[2*n+1] | vov[2*n+2];
`ifdef SVM_ACC_SAT_EN
      nxt[n] = so[n] ? '1 : s[n][MAG_W-1:0];
`else
      nxt[n] = s[n][MAG_W-1:0];
`endif
    end
  end
  // Register every tree level and shift valid/sideband alongside it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nov_q <= '0;
      vld_q <= '0;
      for (int n = 0; n < LANES - 1; n++) node_q[n] <= '0;
      for (int k = 0; k < D; k++) sb_q[k] <= '0;
    end else begin
      nov_q    <= so;
      vld_q[0] <= valid_i;
      sb_q[0]  <= sb_i;
      for (int n = 0; n < LANES - 1; n++) node_q[n] <= nxt[n];
      for (int k = 1; k < D; k++) begin
        vld_q[k] <= vld_q[k-1];
        sb_q[k]  <= sb_q[k-1];
      end
    end
  end
  assign valid_o = vld_q[D-1];
  assign sb_o    = sb_q[D-1];
  assign sum_o   = node_q[0];
  assign ovf_o   = nov_q[0];
endmodule

// File: rtl/svm_kernel_accum.sv
// svm_kernel_accum: multi-beat kernel-term reduction, per-vector accumulation and tagged alpha combine; SVM_ACC_SAT_EN selects saturation
module svm_kernel_accum
  import svm_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int MAG_W  = 30,
  parameter int ADDR_W = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic                          in_last_i,
  input  logic [ADDR_W-1:0]             in_svm_i,
  input  logic [LANES*(MAG_W+2)-1:0]    in_terms_i,
  output logic [ADDR_W-1:0]             ai_addr_o,
  input  logic [MAG_W+1:0]              ai_data_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [MAG_W+1:0]              out_ai_o,
  output logic [ADDR_W-1:0]             out_svm_o,
  output logic                          out_ovf_o
);
  localparam int W = MAG_W + 2;
  localparam logic [W-1:0] ZW = W'(zero_word(W));
  state_e           state_q, state_d;
  logic             rdy_q;
  logic [ADDR_W-1:0] svm_q;
  logic [W-1:0]     ai_hold_q;
  logic [MAG_W-1:0] acc_q;
  logic             acc_ovf_q, acc_done_q;
  logic [W-1:0]     out_ai_q;
  logic             out_ovf_q;
  logic             accept, t_valid, t_ovf, t_first, t_last;
  logic [MAG_W-1:0] t_sum;
  logic [1:0]       t_sb;
  logic [MAG_W-1:0] a_base, a_m, c_m;
  logic [MAG_W:0]   a_s, c_s;
  logic             a_o, c_o, c_live;
  logic [1:0]       ai_tag;
  assign accept = in_valid_i & in_ready_o;
  svm_adder_tree #(.LANES(LANES), .MAG_W(MAG_W), .SB_W(2)) u_tree (
    .clk(clk), .rst(rst), .valid_i(accept), .terms_i(in_terms_i),
    .sb_i({state_q == IDLE, in_last_i}),
    .valid_o(t_valid), .sum_o(t_sum), .ovf_o(t_ovf), .sb_o(t_sb)
  );
  assign {t_first, t_last} = t_sb;
  // FSM state register; rdy_q holds in_ready low until the first edge after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
    end
  end
  // FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? (in_last_i ? DRAIN : ACCUM) : IDLE;
      ACCUM:   state_d = (accept && in_last_i) ? DRAIN : ACCUM;
      DRAIN:   state_d = acc_done_q ? HOLD : DRAIN;
      HOLD:    state_d = out_ready_i ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  // FSM outputs
  always_comb begin
    in_ready_o  = rdy_q && (state_q == IDLE || state_q == ACCUM);
    out_valid_o = state_q == HOLD;
  end
  // Accumulate and combine arithmetic; a first beat restarts the accumulator from zero
  always_comb begin
    a_base = t_first ? '0 : acc_q;
    a_s    = {1'b0, a_base} + {1'b0, t_sum};
    a_o    = (~t_first & acc_ovf_q) | t_ovf | a_s[MAG_W];
    ai_tag = ai_hold_q[W-1:W-2];
    c_live = ai_tag == TAG_POS || ai_tag == TAG_NEG;
    c_s    = {1'b0, ai_hold_q[MAG_W-1:0]} + {1'b0, acc_q};
    c_o    = acc_ovf_q | c_s[MAG_W];
`ifdef SVM_ACC_SAT_EN
    a_m = a_o ? '1 : a_s[MAG_W-1:0];
    c_m = c_o ? '1 : c_s[MAG_W-1:0];
`else
    a_m = a_s[MAG_W-1:0];
    c_m = c_s[MAG_W-1:0];
`endif
  end
  // Index latch, alpha capture, accumulator and combined result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      svm_q      <= '0;
      ai_hold_q  <= '0;
      acc_q      <= '0;
      acc_ovf_q  <= 1'b0;
      acc_done_q <= 1'b0;
      out_ai_q   <= ZW;
      out_ovf_q  <= 1'b0;
    end else begin
      ai_hold_q  <= ai_data_i;
      acc_done_q <= t_valid & t_last;
      if (state_q == IDLE && accept) svm_q <= in_svm_i;
      if (t_valid) begin
        acc_q     <= a_m;
        acc_ovf_q <= a_o;
      end
      if (acc_done_q) begin
        out_ai_q  <= c_live ? {ai_tag, c_m} : ZW;
        out_ovf_q <= c_live & c_o;
      end
    end
  end
  assign ai_addr_o = svm_q;
  assign out_svm_o = svm_q;
  assign out_ai_o  = out_ai_q;
  assign out_ovf_o = out_ovf_q;
endmodule

// File: doc/svm_kernel_accum.md
# svm_kernel_accum

Parametrised successor to the fixed four-lane kernel/alpha adder of the SVM Gaussian classifier. It accepts one or more beats of LANES tagged kernel terms per support vector and reduces them through a pipelined adder tree into a per-vector accumulator. It combines the sum with the support vector's tagged alpha word, read from external synchronous RAM, and presents the tagged result on a valid/ready output toward the decision-sum stage.

## Interface
- LANES, 4, terms per beat; power of two, 2..16
- MAG_W, 30, magnitude width; tagged word width W = MAG_W+2
- ADDR_W, 10, support-vector index width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  beat valid
- in_ready  out  1  beat accept; reset 0
- in_last  in  1  final beat of current support vector
- in_svm  in  ADDR_W  support-vector index, sampled on first beat of a vector
- in_terms  in  LANES*W  tagged kernel terms, lane 0 in LSBs
- ai_addr  out  ADDR_W  alpha RAM read address; reset 0
- ai_data  in  W  alpha RAM data, valid one cycle after ai_addr changes
- out_valid  out  1  result valid; reset 0
- out_ready  in  1  result accept
- out_ai  out  W  tagged result; reset {2'b10, 0}
- out_svm  out  ADDR_W  index of result; reset 0
- out_ovf  out  1  magnitude overflow occurred in this result; reset 0

## Operation
- Tag field [W-1:W-2]: 00 positive, 01 negative, 10 zero, 11 invalid (treated as zero).
- Lane terms: tag 10/11 contributes 0. Tags 00/01 contribute the magnitude; lane sign is ignored.
- FSM states: IDLE (in_ready=1), ACCUM (in_ready=1), DRAIN (in_ready=0, pipeline emptying), HOLD (out_valid=1, in_ready=0).
- IDLE + accepted beat: latch in_svm into ai_addr and out_svm, then go to ACCUM. If in_last is set, go to DRAIN instead. ai_data is captured into ai_hold on the following cycle.
- ACCUM: accept beats back-to-back. An accepted beat with in_last set moves the FSM to DRAIN.
- DRAIN: when the last beat exits the combine stage, go to HOLD.
- HOLD: out_valid=1. out_ai, out_svm and out_ovf stay stable until out_valid && out_ready, then go to IDLE.
- Combine step, using ai_hold tag: 00 gives {00, ai+sum}. 01 gives {01, ai+sum} (magnitudes add). 10/11 gives {10, 0} with out_ovf=0.
- Arithmetic: the adder tree, accumulator and combine are all MAG_W bits. Any carry out of bit MAG_W-1 at any stage sets out_ovf for that vector.
- Accumulator clears when a vector's first beat enters the accumulate stage.
- Reset, including mid-vector: all state, pipeline registers and the accumulator clear. The FSM returns to IDLE. No out_valid is produced for the interrupted vector.

## Timing
- Tree depth D = log2(LANES) register stages.
- Beat accepted in cycle 0: tree output registered at cycle D, accumulator updated at cycle D+1, combine and out_valid at cycle D+2 after the last beat. For LANES=4 this is cycle 4.
- in_ready rises on the first clock edge after rst deasserts.
- Throughput while in ACCUM: one beat per cycle.
- The next vector can be accepted on the cycle after the out handshake (IDLE).
- in_valid while in_ready=0 is ignored; the source holds the beat.

## Configuration
- SVM_ACC_SAT_EN defined: on overflow, magnitude saturates to all ones at the stage where it occurs, and at every later stage. out_ovf=1.
- SVM_ACC_SAT_EN undefined: magnitude wraps modulo 2^MAG_W. out_ovf still reports the carry.

## Structure
- Package svm_pkg holds:
  - TAG_POS=2'b00, TAG_NEG=2'b01, TAG_ZERO=2'b10
  - ZERO_WORD function of W
  - FSM state enum
- Sub-module svm_adder_tree: parametrised pipelined LANES-input magnitude tree with tag masking, per-stage overflow propagation and SVM_ACC_SAT_EN saturation.

## Test plan
All scenarios use LANES=4, MAG_W=30.
- Single beat, terms 1,2,3,4 (tag 00), ai {00,10}, in_svm=5 -> out_ai 0x00000014 (20), out_svm 5, out_valid at cycle 4, out_ovf 0.
- Three beats of all-1 terms, ai {01,100} -> out_ai {01,112} = 0x40000070.
- Any terms, ai tag 10 -> out_ai 0x80000000, out_ovf 0. Lane tagged 10 with magnitude 7 among 1,1,1 -> sum 3.
- Four terms 0x3FFFFFFF -> with SVM_ACC_SAT_EN: magnitude 0x3FFFFFFF, out_ovf 1. Without: wrapped value 0x3FFFFFFC, out_ovf 1.
- out_ready held low 5 cycles in HOLD -> out_ai/out_svm stable, in_ready 0. Next vector accepted the cycle after the handshake.
- rst pulsed after beat 2 of a 3-beat vector -> all outputs at reset values. The following single-beat vector 1,1,1,1 with ai {00,0} gives out_ai 4.
